// File: rtl/vga_spot_gen.sv
// -----------------------------------------------------------------------------
// vga_spot_gen
// Spot coordinate generator for the 800x600 VGA raster. Produces the signed
// (spotX, spotY) bus that every sprite and wall renderer compares against its
// own centre, plus hsync/vsync/blank delayed by PIPE_DELAY pixel-enable cycles
// so they line up with the renderers' registered colour codes.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset (priority over ce)
//   ce           in   pixel enable; counters and delay line advance when 1
//   spotX        out  signed 11-bit horizontal coordinate, -HBLANK..HACTIVE-1
//   spotY        out  signed 11-bit vertical coordinate,   -VBLANK..VACTIVE-1
//   line_start   out  combinational pulse at spotX = -HBLANK while ce = 1
//   frame_start  out  combinational pulse at the frame origin while ce = 1
//   hsync        out  horizontal sync, PIPE_DELAY ce-cycles late
//   vsync        out  vertical sync,   PIPE_DELAY ce-cycles late
//   blank        out  1 outside the active area, PIPE_DELAY ce-cycles late
// -----------------------------------------------------------------------------
module vga_spot_gen #(
  parameter int HACTIVE    = 800,
  parameter int HFP        = 56,
  parameter int HSYNC      = 120,
  parameter int HBP        = 64,
  parameter int VACTIVE    = 600,
  parameter int VFP        = 37,
  parameter int VSYNC      = 6,
  parameter int VBP        = 23,
  parameter int PIPE_DELAY = 2,
  parameter int SYNC_POL   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  output logic signed [10:0] spotX,
  output logic signed [10:0] spotY,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               blank
);

  localparam int HBLANK = HFP + HSYNC + HBP;
  localparam int VBLANK = VFP + VSYNC + VBP;

  // Blanking positions are negative, so the origin of every line/frame is
  // -HBLANK / -VBLANK and the sync window sits just before the back porch.
  localparam logic signed [10:0] X_MIN   = 11'(-HBLANK);
  localparam logic signed [10:0] X_MAX   = 11'(HACTIVE - 1);
  localparam logic signed [10:0] Y_MIN   = 11'(-VBLANK);
  localparam logic signed [10:0] Y_MAX   = 11'(VACTIVE - 1);
  localparam logic signed [10:0] HS_LO   = 11'(-HSYNC - HBP);
  localparam logic signed [10:0] HS_HI   = 11'(-HBP - 1);
  localparam logic signed [10:0] VS_LO   = 11'(-VSYNC - VBP);
  localparam logic signed [10:0] VS_HI   = 11'(-VBP - 1);
  localparam logic               SYNC_OFF = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  // {hsync, vsync, blank} value held in every delay stage after reset
  localparam logic [2:0] IDLE_BITS = {SYNC_OFF, SYNC_OFF, 1'b1};

  logic hs_raw_s;
  logic vs_raw_s;
  logic bl_raw_s;

  // Spot counters: X wraps at the end of the active line and carries into Y.
  always_ff @(posedge clk) begin
    if (reset) begin
      spotX <= X_MIN;
      spotY <= Y_MIN;
    end else if (ce) begin
      if (spotX == X_MAX) begin
        spotX <= X_MIN;
        if (spotY == Y_MAX) begin
          spotY <= Y_MIN;
        end else begin
          spotY <= spotY + 11'sd1;
        end
      end else begin
        spotX <= spotX + 11'sd1;
      end
    end
  end

  // Undelayed sync/blank decoded from the current spot (signed compares).
  assign hs_raw_s = ((spotX >= HS_LO) && (spotX <= HS_HI)) ^ SYNC_OFF;
  assign vs_raw_s = ((spotY >= VS_LO) && (spotY <= VS_HI)) ^ SYNC_OFF;
  assign bl_raw_s = (spotX < 11'sd0) || (spotY < 11'sd0);

  // Preload strobes are not delayed: renderers need them at the spot itself.
  assign line_start  = ce && (spotX == X_MIN);
  assign frame_start = ce && (spotX == X_MIN) && (spotY == Y_MIN);

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign hsync = hs_raw_s;
      assign vsync = vs_raw_s;
      assign blank = bl_raw_s;
    end else begin : g_delay
      logic [2:0] dly_r [PIPE_DELAY];

      // Shift register advancing only on ce so alignment is in pixel cycles.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            dly_r[i] <= IDLE_BITS;
          end
        end else if (ce) begin
          dly_r[0] <= {hs_raw_s, vs_raw_s, bl_raw_s};
          for (int i = 1; i < PIPE_DELAY; i++) begin
            dly_r[i] <= dly_r[i-1];
          end
        end
      end

      assign hsync = dly_r[PIPE_DELAY-1][2];
      assign vsync = dly_r[PIPE_DELAY-1][1];
      assign blank = dly_r[PIPE_DELAY-1][0];
    end
  endgenerate

endmodule

// File: doc/vga_spot_gen.md
Name: vga_spot_gen

Overview:
- Drives the spot coordinate bus (spotX, spotY) consumed by every sprite and wall renderer, plus the VGA sync and blanking signals for the 800x600 active area.
- Sync and blank are delayed by a configurable pipeline depth, so they line up with the registered colour codes coming back from the renderers.
- Coordinates are signed: blanking-interval positions are negative, and active pixels run 0..HACTIVE-1 / 0..VACTIVE-1.

Parameters:
- HACTIVE, 800, active pixels per line
- HFP, 56, horizontal front porch (pixels)
- HSYNC, 120, horizontal sync width (pixels)
- HBP, 64, horizontal back porch (pixels)
- VACTIVE, 600, active lines per frame
- VFP, 37, vertical front porch (lines)
- VSYNC, 6, vertical sync width (lines)
- VBP, 23, vertical back porch (lines)
- PIPE_DELAY, 2, cycles of delay on hsync/vsync/blank, range 0..7
- SYNC_POL, 1, sync polarity; 1 = active-high pulses

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ce  input  1  pixel enable; counters advance only when ce=1
- spotX  output  11 signed  current horizontal coordinate
- spotY  output  11 signed  current vertical coordinate
- line_start  output  1  one-cycle pulse while spotX = -HBLANK (and ce=1)
- frame_start  output  1  one-cycle pulse while spotX = -HBLANK, spotY = -VBLANK (and ce=1)
- hsync  output  1  horizontal sync, delayed PIPE_DELAY cycles
- vsync  output  1  vertical sync, delayed PIPE_DELAY cycles
- blank  output  1  1 outside the active area, delayed PIPE_DELAY cycles

Behaviour:
- Derived constants: HBLANK = HFP+HSYNC+HBP (240); VBLANK = VFP+VSYNC+VBP (66).
- spotX range: -HBLANK .. HACTIVE-1 (-240..799).
- spotY range: -VBLANK .. VACTIVE-1 (-66..599).
- All of these ranges fit signed 11-bit.
- Horizontal order within a line:
  - front porch: spotX -240..-185
  - sync: spotX -184..-65
  - back porch: spotX -64..-1
  - active: spotX 0..799
- Vertical order within a frame:
  - front porch: spotY -66..-30
  - sync: spotY -29..-24
  - back porch: spotY -23..-1
  - active: spotY 0..599
- Counter update, on a rising clk with ce=1:
  - If spotX = HACTIVE-1: spotX <= -HBLANK.
  - Otherwise: spotX <= spotX+1.
  - At the spotX wrap, spotY increments; spotY wraps from VACTIVE-1 to -VBLANK.
- ce=0: spotX, spotY and the delay line all hold. line_start and frame_start are 0.
- Raw (undelayed) sync and blank are combinational on the current spot:
  - hs_raw = (spotX in [-HSYNC-HBP, -HBP-1]), XOR'd with !SYNC_POL.
  - vs_raw is the same test applied to spotY with the V constants.
  - bl_raw = (spotX<0) || (spotY<0).
- Delay line:
  - hs_raw/vs_raw/bl_raw pass through a PIPE_DELAY-stage shift register clocked on ce=1.
  - The outputs seen at a given spot therefore belong to the spot PIPE_DELAY ce-cycles earlier.
  - PIPE_DELAY=0: outputs equal the raw values combinationally.
- line_start and frame_start are undelayed and combinational on the spot and ce. Renderers use them to preload.
- Reset behaviour (reset=1 at a clock edge):
  - spotX <= -240, spotY <= -66.
  - Every delay stage is set to inactive sync (0 when SYNC_POL=1) and blank=1.
  - Reset takes priority over ce.
  - Reset mid-frame restarts at the frame origin on the next cycle. No partial-line state is kept.
- Arithmetic is signed throughout. All comparisons use signed 11-bit operands, so negative spot values compare correctly against the renderers' centerX/centerY.
- Frame period: 1040 x 666 = 692,640 ce-cycles.

Test Plan:
- Reset, ce=1, 1040 cycles:
  - spotX steps -240..799 and wraps to -240.
  - spotY goes -66 -> -65 exactly at the wrap.
  - line_start is high only at spotX=-240.
- Full frame with PIPE_DELAY=0:
  - hsync high for exactly 120 cycles per line, starting at spotX=-184.
  - vsync high for exactly 6 lines, spotY -29..-24.
  - blank=0 exactly 800x600 = 480,000 cycles per frame.
- PIPE_DELAY=2:
  - blank falls when spotX=2, spotY=0 (two cycles after first active pixel).
  - hsync rises at spotX=-182.
- ce toggling 1,0,1,0 with PIPE_DELAY=2:
  - spotX advances once per ce=1.
  - Delay-line alignment is identical to the ce=1 run, counted in ce-cycles.
  - frame_start is never high with ce=0.
- Reset asserted at spotX=300, spotY=250:
  - Next cycle: spotX=-240, spotY=-66, blank=1, hsync=vsync=0.
  - frame_start pulses when ce=1.
- Frame wrap:
  - At spotX=799, spotY=599 with ce=1, the next values are -240/-66.
  - frame_start=1 in that cycle, and frame_start is seen once per 692,640 cycles.
